// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// Wishbone byte-lane patterns and the latched-op payload.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SEL_W  = XLEN / 8;
    localparam int unsigned F3_W   = 3;

    localparam logic [F3_W-1:0] F3_B  = 3'b000;
    localparam logic [F3_W-1:0] F3_H  = 3'b001;
    localparam logic [F3_W-1:0] F3_W32 = 3'b010;
    localparam logic [F3_W-1:0] F3_BU = 3'b100;
    localparam logic [F3_W-1:0] F3_HU = 3'b101;

    localparam logic [SEL_W-1:0] LANE_BYTE = 4'b0001;
    localparam logic [SEL_W-1:0] LANE_HALF = 4'b0011;
    localparam logic [SEL_W-1:0] LANE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Op attributes kept for the duration of a bus cycle
    typedef struct packed {
        logic            is_load;
        logic [F3_W-1:0] funct3;
        logic [1:0]      addr_lo;
    } op_info_t;

    // Stores only define SB/SH/SW; every other code falls back to a full word
    function automatic access_size_e f_access_size(input logic [F3_W-1:0] funct3,
                                                   input logic            is_store);
        access_size_e sz;
        sz = SZ_WORD;
        case (funct3)
            F3_B:  sz = SZ_BYTE;
            F3_H:  sz = SZ_HALF;
            F3_BU: if (!is_store) sz = SZ_BYTE;
            F3_HU: if (!is_store) sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Pure datapath helper: store byte enables and lane replication, load
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [F3_W-1:0]  i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic             i_is_store,
    input  logic [XLEN-1:0]  i_store_data,
    output logic [SEL_W-1:0] o_wr_sel_c,
    output logic [XLEN-1:0]  o_wr_data_c,
    output logic             o_misaligned_c,
    input  logic [F3_W-1:0]  i_ld_funct3,
    input  logic [1:0]       i_ld_addr_lo,
    input  logic [XLEN-1:0]  i_rd_data,
    output logic [XLEN-1:0]  o_load_data_c
);

    access_size_e w_req_size;
    access_size_e w_ld_size;
    logic [7:0]   w_ld_byte;
    logic [15:0]  w_ld_half;
    logic         w_ld_unsigned;

    // Request side: lane select, replicated write data, alignment check
    always_comb begin
        w_req_size     = f_access_size(i_funct3, i_is_store);
        o_wr_sel_c     = LANE_WORD;
        o_wr_data_c    = i_store_data;
        o_misaligned_c = 1'b0;
        case (w_req_size)
            SZ_BYTE: begin
                o_wr_sel_c  = LANE_BYTE << i_addr_lo;
                o_wr_data_c = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
                o_wr_sel_c     = LANE_HALF << {i_addr_lo[1], 1'b0};
                o_wr_data_c    = {2{i_store_data[15:0]}};
                o_misaligned_c = i_addr_lo[0];
            end
            default: begin
                o_wr_sel_c     = LANE_WORD;
                o_wr_data_c    = i_store_data;
                o_misaligned_c = |i_addr_lo;
            end
        endcase
    end

    // Response side: pick the addressed lane and extend to XLEN
    always_comb begin
        w_ld_size     = f_access_size(i_ld_funct3, 1'b0);
        w_ld_unsigned = i_ld_funct3[2];
        w_ld_byte     = 8'(i_rd_data >> {i_ld_addr_lo, 3'b000});
        w_ld_half     = 16'(i_rd_data >> {i_ld_addr_lo[1], 4'b0000});
        o_load_data_c = i_rd_data;
        case (w_ld_size)
            SZ_BYTE: o_load_data_c = {{24{~w_ld_unsigned & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_load_data_c = {{16{~w_ld_unsigned & w_ld_half[15]}}, w_ld_half};
            default: o_load_data_c = i_rd_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding op as a Wishbone-pipelined master,
// with misalignment and ack-timeout exceptions and flush-suppressed completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_is_store,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_addr,
    input  logic [31:0]      ex_store_data,
    input  logic             flush,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_wr_en,
    output logic [31:0]      wb_addr,
    output logic [31:0]      wb_wr_data,
    output logic [3:0]       wb_wr_sel,
    input  logic             wb_ack,
    input  logic             wb_stall,
    input  logic [31:0]      wb_rd_data,
    output logic             mem_done,
    output logic [31:0]      mem_load_data,
    output logic             stall_req,
    output logic             misaligned,
    output logic             bus_err
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    lsu_state_e          r_state;
    lsu_state_e          w_state_nxt;
    op_info_t            r_op;
    op_info_t            w_op_nxt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic                r_flushed;
    logic                w_flushed_nxt;

    logic                r_cyc, r_stb, r_wr_en;
    logic [XLEN-1:0]     r_addr, r_wr_data;
    logic [SEL_W-1:0]    r_sel;
    logic                r_mem_done, r_misaligned, r_bus_err;
    logic [XLEN-1:0]     r_load_data;

    logic                w_cyc_nxt, w_stb_nxt, w_wr_en_nxt;
    logic [XLEN-1:0]     w_addr_nxt, w_wr_data_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                w_mem_done_nxt, w_misaligned_nxt, w_bus_err_nxt;
    logic [XLEN-1:0]     w_load_data_nxt;

    logic                w_accept, w_start, w_reject;
    logic                w_tmo_hit, w_complete;
    logic [SEL_W-1:0]    w_align_sel;
    logic [XLEN-1:0]     w_align_wr_data;
    logic [XLEN-1:0]     w_align_load_data;
    logic                w_align_mis;

    lsu_align u_align (
        .i_funct3       (ex_funct3),
        .i_addr_lo      (ex_addr[1:0]),
        .i_is_store     (ex_is_store),
        .i_store_data   (ex_store_data),
        .o_wr_sel_c     (w_align_sel),
        .o_wr_data_c    (w_align_wr_data),
        .o_misaligned_c (w_align_mis),
        .i_ld_funct3    (r_op.funct3),
        .i_ld_addr_lo   (r_op.addr_lo),
        .i_rd_data      (wb_rd_data),
        .o_load_data_c  (w_align_load_data)
    );

    assign w_accept  = (r_state == ST_IDLE) && ex_valid && (ex_is_load || ex_is_store) && !flush;
    assign w_start   = w_accept && !w_align_mis;
    assign w_reject  = w_accept && w_align_mis;
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign stall_req = (r_state != ST_IDLE) || w_accept;

    assign w_complete = ((r_state == ST_REQ) && !wb_stall && wb_ack) ||
                        ((r_state == ST_WAIT_ACK) && wb_ack);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_tmo_cnt    <= '0;
            r_flushed    <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_sel        <= '0;
            r_mem_done   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_flushed    <= w_flushed_nxt;
            r_cyc        <= w_cyc_nxt;
            r_stb        <= w_stb_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_addr       <= w_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_sel        <= w_sel_nxt;
            r_mem_done   <= w_mem_done_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_bus_err    <= w_bus_err_nxt;
            r_load_data  <= w_load_data_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!wb_stall) w_state_nxt = wb_ack ? ST_IDLE : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (wb_ack || w_tmo_hit) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        w_op_nxt         = r_op;
        w_tmo_nxt        = r_tmo_cnt;
        w_flushed_nxt    = r_flushed | flush;
        w_cyc_nxt        = r_cyc;
        w_stb_nxt        = r_stb;
        w_wr_en_nxt      = r_wr_en;
        w_addr_nxt       = r_addr;
        w_wr_data_nxt    = r_wr_data;
        w_sel_nxt        = r_sel;
        w_mem_done_nxt   = 1'b0;
        w_misaligned_nxt = 1'b0;
        w_bus_err_nxt    = 1'b0;
        w_load_data_nxt  = r_load_data;

        case (r_state)
            ST_IDLE: begin
                w_flushed_nxt    = 1'b0;
                w_misaligned_nxt = w_reject;
                if (w_start) begin
                    w_cyc_nxt     = 1'b1;
                    w_stb_nxt     = 1'b1;
                    w_wr_en_nxt   = ex_is_store;
                    w_addr_nxt    = {ex_addr[31:2], 2'b00};
                    w_wr_data_nxt = ex_is_store ? w_align_wr_data : '0;
                    w_sel_nxt     = w_align_sel;
                    w_tmo_nxt     = '0;
                    w_op_nxt      = '{is_load: ex_is_load, funct3: ex_funct3,
                                      addr_lo: ex_addr[1:0]};
                end
            end
            ST_REQ: begin
                if (!wb_stall) w_stb_nxt = 1'b0;
            end
            ST_WAIT_ACK: begin
                if (!wb_ack) begin
                    if (w_tmo_hit) begin
                        w_cyc_nxt     = 1'b0;
                        w_wr_en_nxt   = 1'b0;
                        w_bus_err_nxt = 1'b1;
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                    end
                end
            end
            default: begin
                w_cyc_nxt = 1'b0;
                w_stb_nxt = 1'b0;
            end
        endcase

        // A flush seen at any point during the bus cycle kills the completion pulse
        if (w_complete) begin
            w_cyc_nxt       = 1'b0;
            w_stb_nxt       = 1'b0;
            w_wr_en_nxt     = 1'b0;
            w_mem_done_nxt  = !(r_flushed || flush);
            w_load_data_nxt = r_op.is_load ? w_align_load_data : '0;
        end
    end

    assign wb_cyc        = r_cyc;
    assign wb_stb        = r_stb;
    assign wb_wr_en      = r_wr_en;
    assign wb_addr       = r_addr;
    assign wb_wr_data    = r_wr_data;
    assign wb_wr_sel     = r_sel;
    assign mem_done      = r_mem_done;
    assign mem_load_data = r_load_data;
    assign misaligned    = r_misaligned;
    assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors, one linear sequence.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic        flush;
    logic        wb_cyc, wb_stb, wb_wr_en;
    logic [31:0] wb_addr, wb_wr_data;
    logic [3:0]  wb_wr_sel;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rd_data;
    logic        mem_done;
    logic [31:0] mem_load_data;
    logic        stall_req, misaligned, bus_err;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ACK_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .flush         (flush),
        .wb_cyc        (wb_cyc),
        .wb_stb        (wb_stb),
        .wb_wr_en      (wb_wr_en),
        .wb_addr       (wb_addr),
        .wb_wr_data    (wb_wr_data),
        .wb_wr_sel     (wb_wr_sel),
        .wb_ack        (wb_ack),
        .wb_stall      (wb_stall),
        .wb_rd_data    (wb_rd_data),
        .mem_done      (mem_done),
        .mem_load_data (mem_load_data),
        .stall_req     (stall_req),
        .misaligned    (misaligned),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
        ex_valid = 1'b1; ex_is_store = st; ex_is_load = !st;
        ex_funct3 = f3; ex_addr = a; ex_store_data = sd;
    endtask

    task automatic idle_ex;
        ex_valid = 1'b0; ex_is_store = 1'b0; ex_is_load = 1'b0;
    endtask

    // Issue op, zero-wait responder acks the cycle after stb is taken
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          output logic [31:0] q_addr, output logic [3:0] q_sel,
                          output logic [31:0] q_wdata, output logic q_done,
                          output logic [31:0] q_ld);
        issue(st, f3, a, sd);
        tick;
        idle_ex;
        q_addr = wb_addr; q_sel = wb_wr_sel; q_wdata = wb_wr_data;
        tick;
        wb_ack = 1'b1; wb_rd_data = rd;
        tick;
        wb_ack = 1'b0; wb_rd_data = '0;
        q_done = mem_done; q_ld = mem_load_data;
    endtask

    logic [31:0] q_addr, q_wdata, q_ld;
    logic [3:0]  q_sel;
    logic        q_done;

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0; wb_rd_data = '0;
        ex_funct3 = '0; ex_addr = '0; ex_store_data = '0;
        idle_ex;
        tick; tick;
        chk("rst_cyc", 32'(wb_cyc), 0);
        chk("rst_stb", 32'(wb_stb), 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_sel", 32'(wb_wr_sel), 0);
        chk("rst_done", 32'(mem_done), 0);
        chk("rst_ld", mem_load_data, 0);
        chk("rst_stall_req", 32'(stall_req), 0);
        rst = 1'b0;
        tick;

        // SW: full word, 3-cycle completion
        issue(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
        #1;
        chk("sw_stall_req_accept", 32'(stall_req), 1);
        tick;
        idle_ex;
        chk("sw_cyc", 32'(wb_cyc), 1);
        chk("sw_stb", 32'(wb_stb), 1);
        chk("sw_we", 32'(wb_wr_en), 1);
        chk("sw_addr", wb_addr, 32'h0000_1004);
        chk("sw_sel", 32'(wb_wr_sel), 32'hF);
        chk("sw_wdata", wb_wr_data, 32'hDEAD_BEEF);
        tick;
        chk("sw_stb_drop", 32'(wb_stb), 0);
        chk("sw_cyc_hold", 32'(wb_cyc), 1);
        chk("sw_no_early_done", 32'(mem_done), 0);
        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
        chk("sw_done", 32'(mem_done), 1);
        chk("sw_cyc_end", 32'(wb_cyc), 0);

        // Loads and stores back to back, each starting in the previous mem_done cycle
        run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("sb_addr", q_addr, 32'h0000_1000);
        chk("sb_sel", 32'(q_sel), 32'h8);
        chk("sb_wdata", q_wdata, 32'hA5A5_A5A5);
        chk("sb_done", 32'(q_done), 1);
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'hA500_0000, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("lb_done", 32'(q_done), 1);
        chk("lb_data", q_ld, 32'hFFFF_FFA5);
        run_op(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'hA500_0000, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("lbu_data", q_ld, 32'h0000_00A5);
        run_op(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_1234, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("lh_data", q_ld, 32'hFFFF_8001);
        run_op(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h8001_1234, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("lhu_data", q_ld, 32'h0000_8001);
        run_op(1'b0, 3'b000, 32'h0000_1001, 32'h0, 32'h0000_7F00, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("lb_pos_data", q_ld, 32'h0000_007F);
        run_op(1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 32'h0, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("sh_sel", 32'(q_sel), 32'hC);
        chk("sh_wdata", q_wdata, 32'hBEEF_BEEF);
        chk("st_ld_zero", q_ld, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_1008, 32'h0, 32'h1234_5678, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("lw_data", q_ld, 32'h1234_5678);
        run_op(1'b0, 3'b011, 32'h0000_100C, 32'h0, 32'hCAFE_F00D, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("unused_f3_addr", q_addr, 32'h0000_100C);
        chk("unused_f3_data", q_ld, 32'hCAFE_F00D);
        tick;
        chk("done_one_cycle", 32'(mem_done), 0);

        // Misaligned LH and SW: no bus cycle
        issue(1'b0, 3'b001, 32'h0000_1001, 32'h0);
        tick;
        idle_ex;
        #1;
        chk("mis_lh_pulse", 32'(misaligned), 1);
        chk("mis_lh_cyc", 32'(wb_cyc), 0);
        chk("mis_lh_stall_req", 32'(stall_req), 0);
        tick;
        chk("mis_lh_pulse_end", 32'(misaligned), 0);
        chk("mis_lh_cyc_later", 32'(wb_cyc), 0);
        issue(1'b1, 3'b010, 32'h0000_1002, 32'h1111_2222);
        tick;
        idle_ex;
        chk("mis_sw_pulse", 32'(misaligned), 1);
        chk("mis_sw_cyc", 32'(wb_cyc), 0);
        tick;

        // Flush in IDLE blocks acceptance
        issue(1'b0, 3'b010, 32'h0000_2000, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_idle_stall_req", 32'(stall_req), 0);
        tick;
        idle_ex; flush = 1'b0;
        chk("flush_idle_cyc", 32'(wb_cyc), 0);

        // Slave stall held 4 cycles in REQ
        issue(1'b1, 3'b001, 32'h0000_2006, 32'h0000_1234);
        tick;
        idle_ex;
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("stall_stb", 32'(wb_stb), 1);
            chk("stall_addr", wb_addr, 32'h0000_2004);
            chk("stall_sel", 32'(wb_wr_sel), 32'hC);
            chk("stall_no_done", 32'(mem_done), 0);
        end
        wb_stall = 1'b0;
        tick;
        chk("stall_release_stb", 32'(wb_stb), 0);
        tick; tick;
        chk("wait_no_done", 32'(mem_done), 0);
        chk("wait_cyc", 32'(wb_cyc), 1);
        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
        chk("stall_done", 32'(mem_done), 1);

        // Ack in the REQ cycle completes directly
        issue(1'b0, 3'b010, 32'h0000_2100, 32'h0);
        tick;
        idle_ex;
        wb_ack = 1'b1; wb_rd_data = 32'h5A5A_0F0F;
        tick;
        wb_ack = 1'b0; wb_rd_data = '0;
        chk("direct_done", 32'(mem_done), 1);
        chk("direct_cyc", 32'(wb_cyc), 0);
        chk("direct_data", mem_load_data, 32'h5A5A_0F0F);
        tick;

        // No ack: bus error after 16 WAIT_ACK cycles
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0);
        tick;
        idle_ex;
        tick;
        for (int i = 0; i < 16; i++) begin
            chk("tmo_cyc_hold", 32'(wb_cyc), 1);
            chk("tmo_no_err", 32'(bus_err), 0);
            if (i != 15) tick;
        end
        tick;
        chk("tmo_bus_err", 32'(bus_err), 1);
        chk("tmo_cyc_drop", 32'(wb_cyc), 0);
        chk("tmo_no_done", 32'(mem_done), 0);
        tick;
        chk("tmo_err_end", 32'(bus_err), 0);
        chk("tmo_stall_req", 32'(stall_req), 0);

        // Reset in WAIT_ACK aborts the op
        issue(1'b1, 3'b010, 32'h0000_4000, 32'h7777_8888);
        tick;
        idle_ex;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_cyc", 32'(wb_cyc), 0);
        chk("rst_mid_stb", 32'(wb_stb), 0);
        chk("rst_mid_we", 32'(wb_wr_en), 0);
        chk("rst_mid_addr", wb_addr, 0);
        chk("rst_mid_wdata", wb_wr_data, 0);
        chk("rst_mid_sel", 32'(wb_wr_sel), 0);
        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
        chk("rst_mid_no_done", 32'(mem_done), 0);
        chk("rst_mid_no_err", 32'(bus_err), 0);

        // Flush in WAIT_ACK: ack consumed, completion suppressed
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        tick;
        idle_ex;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        wb_ack = 1'b1; wb_rd_data = 32'h0BAD_0BAD;
        tick;
        wb_ack = 1'b0; wb_rd_data = '0;
        chk("flush_cyc_end", 32'(wb_cyc), 0);
        chk("flush_no_done", 32'(mem_done), 0);
        tick;
        chk("flush_stays_quiet", 32'(mem_done), 0);
        run_op(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h0600_D000, q_addr, q_sel, q_wdata, q_done, q_ld);
        chk("post_flush_done", 32'(q_done), 1);
        chk("post_flush_data", q_ld, 32'h0600_D000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
